parity_frame_tx: RTL and testbench

//  Serial frame transmitter that sequences the N-bit parity datapath onto a single wire.

---
 rtl/parity_frame_tx_if.sv | 31 +++
 rtl/parity_frame_tx.sv | 150 +++++++++++++++
 tb/tb_parity_frame_tx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_tx_if.sv
// Parallel-side handshake and serial-line bundle for parity_frame_tx.
// Ports (signals):
//   data_in    N  word to transmit
//   valid_in   1  producer has a word on data_in
//   parity_sel 1  0 = even, 1 = odd parity
//   ready_out  1  transmitter can accept a word
//   tx_out     1  serial line, idle high
//   busy       1  frame in progress
//   done       1  one-cycle frame-complete pulse
// master: producer / line observer side; slave: the transmitter.
interface parity_frame_tx_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] data_in;
  logic         valid_in;
  logic         parity_sel;
  logic         ready_out;
  logic         tx_out;
  logic         busy;
  logic         done;

  modport master (
    output data_in, valid_in, parity_sel,
    input  ready_out, tx_out, busy, done
  );

  modport slave (
    input  data_in, valid_in, parity_sel,
    output ready_out, tx_out, busy, done
  );
endinterface

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: accepts a parallel word over valid/ready, computes
// even/odd parity and shifts out start, data (LSB first), parity and stop bits,
// each held BAUD_DIV clocks.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous, active-high reset
//   bus  slave modport of parity_frame_tx_if (data_in, valid_in, parity_sel,
//        ready_out, tx_out, busy, done)
module parity_frame_tx #(
  parameter int unsigned N        = 8,
  parameter int unsigned BAUD_DIV = 4
) (
  input logic               clk,
  input logic               rst,
  parity_frame_tx_if.slave  bus
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [N-1:0]   shift_q, shift_d;
  logic           par_q, par_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic           last_baud;

  assign last_baud = (baud_q == CW'(BAUD_DIV - 1));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    ready_d = 1'b1;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        // ready is high exactly in IDLE, so valid alone means accept
        if (bus.valid_in) begin
          shift_d = bus.data_in;
          par_d   = bus.parity_sel ? ~(^bus.data_in) : (^bus.data_in);
          state_d = START;
        end
      end
      START: begin
        if (last_baud) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (last_baud) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BW'(N - 1)) begin
            bit_d   = '0;
            state_d = PARITY;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      PARITY: begin
        if (last_baud) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (last_baud) begin
          baud_d  = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the upcoming state so they align with it
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  assign bus.tx_out    = tx_q;
  assign bus.busy      = busy_q;
  assign bus.ready_out = ready_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: an N=8/BAUD_DIV=4 instance for the main
// scenarios and an N=4/BAUD_DIV=1 instance for the single-cycle-bit case.
module tb_parity_frame_tx;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  parity_frame_tx_if #(.N(8)) bus8 ();
  parity_frame_tx_if #(.N(4)) bus4 ();

  parity_frame_tx #(.N(8), .BAUD_DIV(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  parity_frame_tx #(.N(4), .BAUD_DIV(1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records one N=8 frame: tx per busy cycle, stops in the done cycle (#1 after edge).
  task automatic capture8(input bit drop, input bit scramble,
                          output logic [63:0] cap, output int nbusy,
                          output int ndone, output int nready_busy,
                          output int nlead, output bit tmo);
    cap = '0; nbusy = 0; ndone = 0; nready_busy = 0; nlead = 0; tmo = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (drop) bus8.valid_in = 1'b0;
      if (bus8.busy) begin
        if (nbusy < 64) cap[nbusy] = bus8.tx_out;
        nbusy++;
        if (bus8.ready_out) nready_busy++;
        if (scramble) begin
          bus8.valid_in   = 1'b1;
          bus8.data_in    = 8'($urandom);
          bus8.parity_sel = 1'($urandom);
        end
      end else if (!bus8.done && nbusy == 0) begin
        nlead++;
      end
      if (bus8.done) begin
        ndone++;
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus8.tx_out, bus8.ready_out, bus8.busy, bus8.done} !== 4'b1100) begin
      $display("FAIL reset8: tx/ready/busy/done=%b required 1100",
               {bus8.tx_out, bus8.ready_out, bus8.busy, bus8.done});
    end else n_pass++;
    n_checks++;
    if ({bus4.tx_out, bus4.ready_out, bus4.busy, bus4.done} !== 4'b1100) begin
      $display("FAIL reset4: tx/ready/busy/done=%b required 1100",
               {bus4.tx_out, bus4.ready_out, bus4.busy, bus4.done});
    end else n_pass++;
  endtask

  task automatic test_parity();
    logic [7:0]  vd [4] = '{8'hA5, 8'hA5, 8'h00, 8'h01};
    logic        vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        vp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [63:0] cap;
    logic [10:0] exp;
    int nbusy, ndone, nrb, nlead;
    bit tmo, ok;
    for (int v = 0; v < 4; v++) begin
      exp = {1'b1, vp[v], vd[v], 1'b0};
      bus8.data_in = vd[v]; bus8.parity_sel = vs[v]; bus8.valid_in = 1'b1;
      capture8(1'b1, 1'b0, cap, nbusy, ndone, nrb, nlead, tmo);
      n_checks++;
      if (tmo) $display("FAIL parity_timeout v%0d: no done within budget", v);
      else n_pass++;
      n_checks++;
      if (nbusy !== 44) $display("FAIL parity_busy_len v%0d: got %0d required 44", v, nbusy);
      else n_pass++;
      for (int b = 0; b < 11; b++) begin
        ok = 1'b1;
        for (int s = 0; s < 4; s++) if (cap[b*4+s] !== exp[b]) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL parity_bit v%0d b%0d: samples %b required %b",
                          v, b, cap[b*4 +: 4], {4{exp[b]}});
        else n_pass++;
      end
      n_checks++;
      if ({bus8.ready_out, bus8.tx_out} !== 2'b11)
        $display("FAIL parity_done_cycle v%0d: ready/tx=%b required 11", v, {bus8.ready_out, bus8.tx_out});
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if ({bus8.done, bus8.busy} !== 2'b00)
        $display("FAIL parity_after_done v%0d: done/busy=%b required 00", v, {bus8.done, bus8.busy});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] cap;
    logic [10:0] exp;
    int nbusy, ndone, nrb, nlead;
    bit tmo, ok;
    bus8.data_in = 8'h3C; bus8.parity_sel = 1'b0; bus8.valid_in = 1'b1;
    for (int f = 0; f < 2; f++) begin
      exp = (f == 0) ? {1'b1, 1'b0, 8'h3C, 1'b0} : {1'b1, 1'b0, 8'hC3, 1'b0};
      capture8(f == 1, 1'b0, cap, nbusy, ndone, nrb, nlead, tmo);
      n_checks++;
      if (tmo || nbusy !== 44) $display("FAIL b2b_len f%0d: busy %0d timeout %0d required 44/0", f, nbusy, tmo);
      else n_pass++;
      ok = 1'b1;
      for (int i = 0; i < 44; i++) if (cap[i] !== exp[i/4]) ok = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL b2b_frame f%0d: got %h required frame of %b", f, cap[43:0], exp);
      else n_pass++;
      n_checks++;
      if (nrb !== 0) $display("FAIL b2b_ready_busy f%0d: ready high %0d busy cycles required 0", f, nrb);
      else n_pass++;
      n_checks++;
      if (bus8.tx_out !== 1'b1) $display("FAIL b2b_gap_high f%0d: tx %b required 1", f, bus8.tx_out);
      else n_pass++;
      if (f == 1) begin
        n_checks++;
        if (nlead !== 0) $display("FAIL b2b_gap f%0d: %0d extra idle cycles required 0", f, nlead);
        else n_pass++;
      end
      bus8.data_in = 8'hC3;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_frame_change();
    logic [63:0] cap;
    logic [10:0] exp;
    int nbusy, ndone, nrb, nlead;
    bit tmo, ok;
    exp = {1'b1, 1'b0, 8'hA5, 1'b0};
    bus8.data_in = 8'hA5; bus8.parity_sel = 1'b0; bus8.valid_in = 1'b1;
    capture8(1'b0, 1'b1, cap, nbusy, ndone, nrb, nlead, tmo);
    bus8.valid_in = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 44; i++) if (cap[i] !== exp[i/4]) ok = 1'b0;
    n_checks++;
    if (tmo || nbusy !== 44 || !ok)
      $display("FAIL midframe_frame: busy %0d timeout %0d frame %h required 44/0 frame of %b",
               nbusy, tmo, cap[43:0], exp);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus8.busy, bus8.ready_out} !== 2'b01)
        $display("FAIL midframe_no_accept c%0d: busy/ready=%b required 01", c, {bus8.busy, bus8.ready_out});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] cap;
    logic [10:0] exp;
    int nbusy, ndone, nrb, nlead, dcount;
    bit tmo, ok;
    bus8.data_in = 8'h96; bus8.parity_sel = 1'b0; bus8.valid_in = 1'b1;
    @(posedge clk); #1;
    bus8.valid_in = 1'b0;
    for (int c = 1; c < 18; c++) begin @(posedge clk); #1; end
    n_checks++;
    if ({bus8.busy, bus8.tx_out} !== 2'b10)
      $display("FAIL rst_pre_bit3: busy/tx=%b required 10", {bus8.busy, bus8.tx_out});
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus8.tx_out, bus8.busy, bus8.ready_out, bus8.done} !== 4'b1010)
      $display("FAIL rst_async: tx/busy/ready/done=%b required 1010",
               {bus8.tx_out, bus8.busy, bus8.ready_out, bus8.done});
    else n_pass++;
    dcount = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) dcount++;
    end
    n_checks++;
    if (dcount !== 0) $display("FAIL rst_no_done: %0d done/busy cycles required 0", dcount);
    else n_pass++;
    exp = {1'b1, 1'b0, 8'h01, 1'b0};
    bus8.data_in = 8'h01; bus8.parity_sel = 1'b1; bus8.valid_in = 1'b1;
    capture8(1'b1, 1'b0, cap, nbusy, ndone, nrb, nlead, tmo);
    ok = 1'b1;
    for (int i = 0; i < 44; i++) if (cap[i] !== exp[i/4]) ok = 1'b0;
    n_checks++;
    if (tmo || nbusy !== 44 || !ok)
      $display("FAIL rst_clean_frame: busy %0d timeout %0d frame %h required 44/0 frame of %b",
               nbusy, tmo, cap[43:0], exp);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_baud1();
    logic [6:0] exp_line;
    logic [6:0] line;
    int nbusy, done_at, ndone;
    exp_line = 7'b1011110;
    line = '0; nbusy = 0; done_at = -1; ndone = 0;
    bus4.data_in = 4'hF; bus4.parity_sel = 1'b0; bus4.valid_in = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      bus4.valid_in = 1'b0;
      if (bus4.busy) begin
        if (nbusy < 7) line[nbusy] = bus4.tx_out;
        nbusy++;
      end
      if (bus4.done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
    end
    n_checks++;
    if (nbusy !== 7) $display("FAIL baud1_len: busy %0d required 7", nbusy);
    else n_pass++;
    n_checks++;
    if (line !== exp_line) $display("FAIL baud1_line: got %b required %b (bit0 first)", line, exp_line);
    else n_pass++;
    n_checks++;
    if (done_at !== 8 || ndone !== 1)
      $display("FAIL baud1_done: at cycle %0d count %0d required 8/1", done_at, ndone);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus8.data_in = '0; bus8.valid_in = 1'b0; bus8.parity_sel = 1'b0;
    bus4.data_in = '0; bus4.valid_in = 1'b0; bus4.parity_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_parity();
    test_back_to_back();
    test_mid_frame_change();
    test_reset_mid_frame();
    test_baud1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
